// File: rtl/cfi_mbox_arbiter.sv
// cfi_mbox_arbiter: shares the CFI mailbox and doorbell between NR_REQ backends.
// Round-robin grant held until the owner's completion IRQ arrives or the wait
// times out. The completion IRQ is routed to the owner only, and IRQs that
// arrive outside the wait are flagged as spurious.
module cfi_mbox_arbiter #(
   parameter  int unsigned NR_REQ         = 4,
   parameter  int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned IDX_W          = $clog2(NR_REQ),
   localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NR_REQ-1:0] req_i,
   input  logic [NR_REQ-1:0] done_i,
   input  logic              mbox_completion_irq_i,
   output logic [NR_REQ-1:0] gnt_o,
   output logic [NR_REQ-1:0] irq_o,
   output logic [IDX_W-1:0]  owner_o,
   output logic              busy_o,
   output logic              timeout_o,
   output logic              spurious_o,
   output logic [15:0]       timeout_cnt_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT    = 2'd1,
      WAIT_IRQ = 2'd2
   } state_e;

   state_e              state_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [IDX_W-1:0]    owner_q;
   logic [NR_REQ-1:0]   gnt_q;
   logic [NR_REQ-1:0]   irq_q;
   logic                timeout_q;
   logic                spurious_q;
   logic [15:0]         tcnt_q;
   logic [CNT_W-1:0]    timer_q;

   logic [IDX_W-1:0]    sel_d;
   logic                found_d;
   logic [IDX_W-1:0]    rr_next_d;
   int unsigned         idx;

   // Round-robin pick: first requester at or above rr_ptr, wrapping around.
   always_comb begin
      sel_d   = '0;
      found_d = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < NR_REQ; i++) begin
         idx = (32'(rr_ptr_q) + i) % NR_REQ;
         if (!found_d && req_i[IDX_W'(idx)]) begin
            sel_d   = IDX_W'(idx);
            found_d = 1'b1;
         end
      end
   end

   // Pointer value that gives priority to the requester after the current owner.
   always_comb begin
      rr_next_d = owner_q + 1'b1;
      if (owner_q == IDX_W'(NR_REQ - 1)) begin
         rr_next_d = '0;
      end
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         gnt_q      <= '0;
         irq_q      <= '0;
         timeout_q  <= 1'b0;
         spurious_q <= 1'b0;
         tcnt_q     <= '0;
         timer_q    <= '0;
      end else begin
         irq_q      <= '0;
         timeout_q  <= 1'b0;
         spurious_q <= mbox_completion_irq_i && (state_q != WAIT_IRQ);
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  state_q <= GRANT;
                  owner_q <= sel_d;
                  gnt_q   <= {{(NR_REQ-1){1'b0}}, 1'b1} << sel_d;
               end
            end
            GRANT: begin
               // done beats a simultaneous request drop
               if (done_i[owner_q]) begin
                  state_q <= WAIT_IRQ;
                  timer_q <= '0;
               end else if (!req_i[owner_q]) begin
                  state_q  <= IDLE;
                  gnt_q    <= '0;
                  rr_ptr_q <= rr_next_d;
               end
            end
            WAIT_IRQ: begin
               // IRQ beats a timeout in the same cycle
               if (mbox_completion_irq_i) begin
                  state_q  <= IDLE;
                  gnt_q    <= '0;
                  irq_q    <= gnt_q;
                  rr_ptr_q <= rr_next_d;
               end else if (timer_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q   <= IDLE;
                  gnt_q     <= '0;
                  timeout_q <= 1'b1;
                  rr_ptr_q  <= rr_next_d;
                  if (tcnt_q != 16'hFFFF) begin
                     tcnt_q <= tcnt_q + 16'd1;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign gnt_o         = gnt_q;
   assign irq_o         = irq_q;
   assign owner_o       = owner_q;
   assign busy_o        = (state_q != IDLE);
   assign timeout_o     = timeout_q;
   assign spurious_o    = spurious_q;
   assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_cfi_mbox_arbiter.sv
// Directed testbench for cfi_mbox_arbiter (NR_REQ=4, TIMEOUT_CYCLES=16).
module tb_cfi_mbox_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  done;
   logic        mirq;
   logic [3:0]  gnt;
   logic [3:0]  irqo;
   logic [1:0]  owner;
   logic        busy;
   logic        tmo;
   logic        spur;
   logic [15:0] tcnt;

   int n_chk  = 0;
   int n_fail = 0;

   cfi_mbox_arbiter #(
      .NR_REQ        (4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .req_i                (req),
      .done_i               (done),
      .mbox_completion_irq_i(mirq),
      .gnt_o                (gnt),
      .irq_o                (irqo),
      .owner_o              (owner),
      .busy_o               (busy),
      .timeout_o            (tmo),
      .spurious_o           (spur),
      .timeout_cnt_o        (tcnt)
   );

   always #5 clk = ~clk;

   // advance one clock and sample 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_o(input string tag, input logic [3:0] g, input logic [3:0] io,
                           input logic [1:0] ow, input logic b, input logic t,
                           input logic s, input logic [15:0] tc);
      chk($sformatf("%s.gnt", tag), 32'(gnt), 32'(g));
      chk($sformatf("%s.irq", tag), 32'(irqo), 32'(io));
      chk($sformatf("%s.owner", tag), 32'(owner), 32'(ow));
      chk($sformatf("%s.busy", tag), 32'(busy), 32'(b));
      chk($sformatf("%s.timeout", tag), 32'(tmo), 32'(t));
      chk($sformatf("%s.spurious", tag), 32'(spur), 32'(s));
      chk($sformatf("%s.tcnt", tag), 32'(tcnt), 32'(tc));
   endtask

   initial begin
      logic [3:0] g;
      rst = 1'b1; req = '0; done = '0; mirq = 1'b0;
      tick(); tick();
      expect_o("reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      rst = 1'b0;

      // single requester full transaction
      req = 4'b0001; tick();
      expect_o("t1_gnt", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      tick();
      expect_o("t1_hold", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      done = 4'b0001; tick(); done = '0;
      expect_o("t1_wait", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      repeat (5) tick();
      req = 4'b0000; tick();
      expect_o("t1_wait_noreq", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      mirq = 1'b1; tick(); mirq = 1'b0;
      expect_o("t1_irq", 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      tick();
      expect_o("t1_irq_end", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);

      // round-robin from a fresh pointer
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         g = 4'b0001 << (k % 4);
         tick();
         expect_o("rr_gnt", g, 4'b0000, 2'(k % 4), 1'b1, 1'b0, 1'b0, 16'd0);
         done = g; tick(); done = '0;
         repeat (4) tick();
         mirq = 1'b1; tick(); mirq = 1'b0;
         expect_o("rr_irq", 4'b0000, g, 2'(k % 4), 1'b0, 1'b0, 1'b0, 16'd0);
      end
      req = 4'b0000;

      // timeout of owner 2, then owner 3 next
      req = 4'b1100; tick();
      expect_o("to_gnt", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0);
      done = 4'b0100; tick(); done = '0;
      for (int k = 0; k < 15; k++) begin
         tick();
         chk("to_wait_busy", 32'(busy), 32'd1);
         chk("to_wait_timeout", 32'(tmo), 32'd0);
      end
      tick();
      expect_o("to_fire", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0, 16'd1);
      tick();
      expect_o("to_next", 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 16'd1);

      // IRQ coinciding with the last timer cycle
      done = 4'b1000; tick(); done = '0;
      repeat (15) tick();
      mirq = 1'b1; tick(); mirq = 1'b0;
      expect_o("collide", 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b0, 16'd1);
      req = 4'b0000; tick();
      expect_o("collide_end", 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 16'd1);

      // spurious IRQ during GRANT
      req = 4'b0001; tick();
      expect_o("sp_gnt", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'd1);
      mirq = 1'b1; tick(); mirq = 1'b0;
      expect_o("sp_grant", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, 16'd1);
      tick();
      expect_o("sp_clear", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'd1);
      req = 4'b0000; tick();
      expect_o("sp_abort", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1);

      // abort by owner 1 and ignored non-owner done
      req = 4'b0110; tick();
      expect_o("ab_gnt", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 16'd1);
      done = 4'b1000; tick(); done = '0;
      expect_o("ab_nonowner", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 16'd1);
      req = 4'b0100; tick();
      expect_o("ab_idle", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 16'd1);
      tick();
      expect_o("ab_next", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 16'd1);

      // done and request drop together: done wins
      req = 4'b0000; done = 4'b0100; tick(); done = '0;
      expect_o("dd_wait", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 16'd1);
      tick();
      expect_o("dd_wait2", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 16'd1);

      // reset in the middle of WAIT_IRQ
      rst = 1'b1; tick(); rst = 1'b0;
      expect_o("rst_mid", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      mirq = 1'b1; tick(); mirq = 1'b0;
      expect_o("rst_spur", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 16'd0);
      req = 4'b0110; tick();
      expect_o("rst_rr", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cfi_mbox_arbiter.md
Name: cfi_mbox_arbiter

Overview:
- Shares the single CFI mailbox and its doorbell between NR_REQ CFI backend requesters, e.g. per-hart backends or a backend plus a debug/test injector.
- Round-robin grant; the grant is held until the owner's transaction completes.
- Routes the shared mailbox completion IRQ back to the owner only.
- Bounds each wait with a timeout so one lost IRQ cannot deadlock the others.

Parameters:
- NR_REQ, 4: number of requesters, ≥2.
- TIMEOUT_CYCLES, 1024: max cycles spent in WAIT_IRQ, ≥2.
- IDX_W, $clog2(NR_REQ): owner index width (derived).
- CNT_W, $clog2(TIMEOUT_CYCLES): timer width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NR_REQ  level request per requester.
- done_i  in  NR_REQ  1-cycle pulse: owner has written its mailbox and doorbell.
- mbox_completion_irq_i  in  1  completion pulse from the mailbox.
- gnt_o  out  NR_REQ  one-hot grant, registered.
- irq_o  out  NR_REQ  routed completion pulse, registered.
- owner_o  out  IDX_W  current or last owner index.
- busy_o  out  1  arbiter not in IDLE.
- timeout_o  out  1  1-cycle pulse on timeout.
- spurious_o  out  1  1-cycle pulse when an IRQ arrives outside WAIT_IRQ.
- timeout_cnt_o  out  16  saturating timeout counter.

Behaviour:
- Reset (rst_i high at a clock edge), outputs: gnt_o=0, irq_o=0, owner_o=0, busy_o=0, timeout_o=0, spurious_o=0, timeout_cnt_o=0.
- Reset, internal state: state=IDLE, rr_ptr=0, timer=0.
- Reset mid-transaction aborts immediately. No irq_o is emitted for the aborted owner.
- FSM states: IDLE, GRANT, WAIT_IRQ. All outputs are registered.
- IDLE: if any req_i is high, select the first set bit searching upward from rr_ptr with wrap. Next cycle: state=GRANT, owner_o=sel, gnt_o=onehot(sel), busy_o=1. Latency from req_i to gnt_o is 1 cycle.
- GRANT, owner's done_i: done_i[owner] high → next cycle WAIT_IRQ, timer=0, gnt_o held.
- GRANT, abort: req_i[owner] low without done_i → next cycle IDLE, gnt_o=0, rr_ptr=owner+1 mod NR_REQ.
- GRANT, done and drop together: done_i[owner] high in the same cycle as req_i[owner] low → done wins, go to WAIT_IRQ.
- done_i from any non-owner is ignored in every state.
- WAIT_IRQ, gnt_o: stays asserted. req_i changes are ignored.
- WAIT_IRQ, timer: increments by 1 each cycle.
- WAIT_IRQ, completion: mbox_completion_irq_i high → next cycle IDLE, gnt_o=0, irq_o[owner]=1 for exactly 1 cycle, rr_ptr=owner+1 mod NR_REQ.
- WAIT_IRQ, timeout: timer==TIMEOUT_CYCLES-1 with no IRQ → next cycle IDLE, gnt_o=0, timeout_o=1 for 1 cycle, no irq_o, rr_ptr advances. timeout_cnt_o increments, saturating at 0xFFFF.
- IRQ and timeout in the same cycle: the IRQ wins and the timeout is not counted.
- Spurious IRQ: mbox_completion_irq_i in IDLE or GRANT → spurious_o=1 next cycle, otherwise dropped. It has no effect on state.
- Owner turnaround: at least 1 IDLE cycle between owners; gnt_o is never high for two different indices on adjacent cycles.
- Fairness: with all req_i held high, grants rotate 0,1,2,3,0,… No requester waits more than NR_REQ-1 transactions.
- owner_o holds the last owner while in IDLE.

Test Plan:
- Single requester, rst_i released, req_i=0001 at cycle 0.
  - gnt_o=0001 at cycle 1.
  - done_i[0] at cycle 3 → busy_o stays 1, WAIT_IRQ from cycle 4.
  - IRQ at cycle 10 → cycle 11: irq_o=0001, gnt_o=0000; irq_o=0 at cycle 12.
- Round-robin: req_i=1111 held, each owner sends done then IRQ 5 cycles later.
  - Grant order is 0,1,2,3,0.
  - At least 1 cycle with gnt_o=0 between owners.
  - irq_o is always equal to the previous gnt_o.
- Timeout with TIMEOUT_CYCLES=16: owner 2 done, no IRQ.
  - Exactly 16 cycles in WAIT_IRQ, then timeout_o=1 pulse, timeout_cnt_o=1, irq_o=0.
  - Next grant goes to 3 if it is requesting.
- Collision and spurious:
  - IRQ on the same cycle as timer==15 → irq_o pulses, timeout_o stays 0, timeout_cnt_o unchanged.
  - IRQ while in GRANT → spurious_o=1, state stays GRANT.
- Abort and non-owner done:
  - Owner 1 drops req_i in GRANT → IDLE next cycle; requester 2 is granted 1 cycle after that.
  - done_i[3] pulsed while owner is 1 → ignored.
- Reset mid-WAIT_IRQ: rst_i high for 1 cycle.
  - All outputs are 0 the next cycle and rr_ptr=0.
  - A later IRQ produces spurious_o=1 and no irq_o.
